// File: rtl/wb_arb_pkg.sv
// Shared word/register-address definitions and the LSU result entry type.
`ifndef WB_ARB_SPEC_DEFS
`define WB_ARB_SPEC_DEFS
`define BITNESS 32
`define WORD [`BITNESS-1:0]
`define RADDR [4:0]
`define MIRROR_LIM 'h10
`endif

package wb_arb_pkg;
  localparam int WORD_W     = `BITNESS;
  localparam int MIRROR_LIM = `MIRROR_LIM;

  typedef logic `RADDR raddr_t;
  typedef logic `WORD  word_t;

  typedef struct packed {
    raddr_t a;
    word_t  d;
  } entry_t;
endpackage

// File: rtl/wb_arb_if.sv
// Writeback arbiter bus: ALU and LSU result inputs, register-file port, hazard exports.
interface wb_arb_if #(parameter int QDEPTH = 4);
  import wb_arb_pkg::*;

  logic                  alu_v;
  raddr_t                alu_a;
  word_t                 alu_d;
  logic                  alu_hold;
  logic                  lsu_v;
  logic                  lsu_rdy;
  raddr_t                lsu_a;
  word_t                 lsu_d;
  logic                  w;
  raddr_t                wa;
  word_t                 wval;
  logic [31:0]           pend;
  logic [$clog2(QDEPTH):0] qcnt;

  modport master (
    output alu_v, alu_a, alu_d, lsu_v, lsu_a, lsu_d,
    input  alu_hold, lsu_rdy, w, wa, wval, pend, qcnt
  );

  modport slave (
    input  alu_v, alu_a, alu_d, lsu_v, lsu_a, lsu_d,
    output alu_hold, lsu_rdy, w, wa, wval, pend, qcnt
  );
endinterface

// File: rtl/wb_fifo.sv
// LSU result FIFO of {addr, data} entries; exposes per-slot valid and address for hazard tracking.
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push_i,
  input  entry_t                    push_e_i,
  input  logic                      pop_i,
  output entry_t                    head_o,
  output logic [$clog2(QDEPTH):0]   count_o,
  output logic [QDEPTH-1:0]         vld_o,
  output raddr_t [QDEPTH-1:0]       addr_o
);
  localparam int PW = $clog2(QDEPTH);

  entry_t          mem_q [QDEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign push_ok = push_i && (cnt_q < (PW+1)'(QDEPTH));
  assign pop_ok  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_e_i;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    vld_o  = '0;
    addr_o = '0;
    off    = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      off       = PW'(i) - rd_q;
      vld_o[i]  = ({1'b0, off} < cnt_q);
      addr_o[i] = mem_q[i].a;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: ALU always wins, queued LSU results drain in idle cycles, starvation raises alu_hold.
module wb_arb
  import wb_arb_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int STARVE = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  wb_arb_if.slave  bus
);
  localparam int SW = $clog2(STARVE + 1);

  entry_t                  head;
  logic [$clog2(QDEPTH):0] cnt;
  logic [QDEPTH-1:0]       vld;
  raddr_t [QDEPTH-1:0]     addr;
  logic                    rdy, push, pop, empty;

  logic          w_q;
  raddr_t        wa_q;
  word_t         wval_q;
  logic [SW-1:0] starve_q;

  assign empty = (cnt == '0);
  assign rdy   = (cnt < ($clog2(QDEPTH)+1)'(QDEPTH));
  assign push  = bus.lsu_v && rdy;
  assign pop   = !bus.alu_v && !empty;

  wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .push_e_i ('{a: bus.lsu_a, d: bus.lsu_d}),
    .pop_i    (pop),
    .head_o   (head),
    .count_o  (cnt),
    .vld_o    (vld),
    .addr_o   (addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q      <= 1'b0;
      wa_q     <= '0;
      wval_q   <= '0;
      starve_q <= '0;
    end else begin
      if (bus.alu_v) begin
        w_q    <= 1'b1;
        wa_q   <= bus.alu_a;
        wval_q <= bus.alu_d;
      end else if (pop) begin
        w_q    <= 1'b1;
        wa_q   <= head.a;
        wval_q <= head.d;
      end else begin
        w_q <= 1'b0;
      end

      if (empty || pop)                   starve_q <= '0;
      else if (starve_q != SW'(STARVE))   starve_q <= starve_q + 1'b1;
    end
  end

  // Low-bank destinations also mark their high-bank mirror.
  always_comb begin
    bus.pend = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (vld[i]) begin
        bus.pend[addr[i]] = 1'b1;
        if (addr[i] < 5'(MIRROR_LIM)) bus.pend[{1'b1, addr[i][3:0]}] = 1'b1;
      end
    end
  end

  assign bus.alu_hold = (starve_q == SW'(STARVE));
  assign bus.lsu_rdy  = rdy;
  assign bus.qcnt     = cnt;
  assign bus.w        = w_q;
  assign bus.wa       = wa_q;
  assign bus.wval     = wval_q;
endmodule
